// File: rtl/debug_scratch_pkg.sv
// Shared types and default geometry for the debug instruction RAM scratch loader.
// Defaults follow the debug instruction RAM's row count and row width.
package debug_scratch_pkg;

    localparam int DEBUG_INST_RAM_LOG       = 8;
    localparam int DEBUG_INST_RAM_WIDTH_LOG = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } scratch_state_t;

endpackage

// File: rtl/debug_scratch_loader_if.sv
// Host-side command, write-stream and read-stream bundle of the scratch loader.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits for ready, and a sender holds its payload stable while valid && !ready.
interface debug_scratch_loader_if
    import debug_scratch_pkg::*;
#(
    parameter int RAM_LOG   = DEBUG_INST_RAM_LOG,
    parameter int WIDTH_LOG = DEBUG_INST_RAM_WIDTH_LOG,
    parameter int AW        = RAM_LOG + WIDTH_LOG
);

    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic               cmd_write_i;
    logic [RAM_LOG-1:0] cmd_base_i;
    logic [AW-1:0]      cmd_len_i;

    logic               wdata_valid_i;
    logic [7:0]         wdata_i;
    logic               wdata_ready_o;

    logic               rdata_valid_o;
    logic [7:0]         rdata_o;
    logic               rdata_ready_i;

    logic               done_o;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_base_i, cmd_len_i,
        input  wdata_valid_i, wdata_i, rdata_ready_i,
        output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_base_i, cmd_len_i,
        output wdata_valid_i, wdata_i, rdata_ready_i,
        input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o
    );

endinterface

// File: rtl/debug_scratch_addr_map.sv
// Maps a linear byte offset to the scratch port's {lane, row} address:
// the byte lane goes to the MSBs, the row to the LSBs.
module debug_scratch_addr_map #(
    parameter int WIDTH_LOG = 3,
    parameter int AW        = 11
) (
    input  logic [AW-1:0] off_i,
    output logic [AW-1:0] addr_o
);

    assign addr_o = {off_i[WIDTH_LOG-1:0], off_i[AW-1:WIDTH_LOG]};

endmodule

// File: rtl/debug_scratch_loader.sv
// Burst sequencer on the debug instruction RAM scratch port: turns host write/read
// bursts into lane/row scratch accesses and holds the core off while busy.
module debug_scratch_loader
    import debug_scratch_pkg::*;
#(
    parameter int RAM_LOG   = DEBUG_INST_RAM_LOG,
    parameter int WIDTH_LOG = DEBUG_INST_RAM_WIDTH_LOG,
    parameter int AW        = RAM_LOG + WIDTH_LOG
) (
    input  logic                  clk,
    input  logic                  reset,
    debug_scratch_loader_if.slave host,
    output logic                  core_hold_o,
    output logic [AW-1:0]         scratch_addr_o,
    output logic [7:0]            scratch_wr_data_o,
    output logic                  scratch_wr_en_o,
    input  logic [7:0]            scratch_rd_data_i,
    output scratch_state_t        state_o
);

    localparam logic [AW-1:0] OFF_ONE = AW'(1);

    scratch_state_t     state_q;
    logic [AW-1:0]      off_q;
    logic [AW-1:0]      rem_q;
    logic               rvalid_q;
    logic [7:0]         rdata_q;
    logic [RAM_LOG-1:0] base_w;
    logic               out_free;

    assign base_w = host.cmd_base_i;
    // The read output register may take a new byte when empty or when drained this cycle.
    assign out_free = !rvalid_q || host.rdata_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            off_q    <= '0;
            rem_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.cmd_valid_i) begin
                        off_q   <= {base_w, {WIDTH_LOG{1'b0}}};
                        rem_q   <= host.cmd_len_i;
                        state_q <= host.cmd_write_i ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (host.wdata_valid_i) begin
                        off_q <= off_q + OFF_ONE;
                        rem_q <= rem_q - OFF_ONE;
                        if (rem_q == '0) state_q <= S_DONE;
                    end
                end
                S_READ: begin
                    if (out_free) begin
                        rdata_q  <= scratch_rd_data_i;
                        rvalid_q <= 1'b1;
                        off_q    <= off_q + OFF_ONE;
                        rem_q    <= rem_q - OFF_ONE;
                        if (rem_q == '0) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_free) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    debug_scratch_addr_map #(
        .WIDTH_LOG(WIDTH_LOG),
        .AW       (AW)
    ) u_addr_map (
        .off_i (off_q),
        .addr_o(scratch_addr_o)
    );

    assign host.cmd_ready_o   = (state_q == S_IDLE);
    assign host.wdata_ready_o = (state_q == S_WRITE);
    assign host.rdata_valid_o = rvalid_q;
    assign host.rdata_o       = rdata_q;
    assign host.done_o        = (state_q == S_DONE) && out_free;
    assign core_hold_o        = (state_q != S_IDLE);
    // Reset suppresses the strobe so a byte offered on the reset edge never lands in RAM.
    assign scratch_wr_en_o    = (state_q == S_WRITE) && host.wdata_valid_i && !reset;
    assign scratch_wr_data_o  = host.wdata_i;
    assign state_o            = state_q;

endmodule

// File: doc/debug_scratch_loader.md
# debug_scratch_loader

Sequencer that owns the byte-wide scratch port of the debug instruction RAM. It accepts burst commands from the debug host, converts a linear byte stream into the RAM's lane/row scratch address format, and streams write bytes in or read bytes out under valid/ready flow control. It sits between the debug host interface and the instruction scratch pad, and it holds fetch off the RAM while a burst is in flight.

## Interface
Parameters:
- `RAM_LOG`, default 8: log2 of RAM rows; equals `DEBUG_INST_RAM_LOG`.
- `WIDTH_LOG`, default 3: log2 of bytes per row; equals `DEBUG_INST_RAM_WIDTH_LOG`.
- `AW`, default `RAM_LOG+WIDTH_LOG`: byte-address and length width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  high only in IDLE.
- `cmd_write_i`  in  1  1 = write burst, 0 = read burst.
- `cmd_base_i`  in  RAM_LOG  starting row.
- `cmd_len_i`  in  AW  byte count minus one.
- `wdata_valid_i`  in  1  write byte offered.
- `wdata_i`  in  8  write byte.
- `wdata_ready_o`  out  1  high in WRITE.
- `rdata_valid_o`  out  1  read byte valid (registered).
- `rdata_o`  out  8  read byte.
- `rdata_ready_i`  in  1  host accepts read byte.
- `done_o`  out  1  one-cycle pulse at burst end.
- `core_hold_o`  out  1  high whenever state is not IDLE.
- `scratch_addr_o`  out  AW  to `instScratchAddr_i`.
- `scratch_wr_data_o`  out  8  to `instScratchWrData_i`.
- `scratch_wr_en_o`  out  1  to `instScratchWrEn_i`.
- `scratch_rd_data_i`  in  8  from `instScratchRdData_o`; combinational read.

## Operation
- Internal registers: linear byte offset `off` (AW bits), remaining count `rem` (AW bits).
- Address mapping: `scratch_addr_o = {off[WIDTH_LOG-1:0], off[AW-1:WIDTH_LOG]}`, with the byte lane in the MSBs and the row in the LSBs.
- `off` increments modulo 2^AW. After the last byte of the last row it wraps to row 0, lane 0.
- FSM states are IDLE, WRITE, READ and DONE.
- IDLE: on `cmd_valid_i`, load `off = {cmd_base_i, WIDTH_LOG'b0}` and `rem = cmd_len_i`, then go to WRITE or READ according to `cmd_write_i`.
- WRITE:
  - `scratch_wr_en_o = wdata_valid_i` (combinational) and `scratch_wr_data_o = wdata_i`.
  - On each handshake, `off++` and `rem--`.
  - The handshake with `rem==0` moves the FSM to DONE.
- READ:
  - The output register loads `scratch_rd_data_i` at the current `off` when `!rdata_valid_o || rdata_ready_i`. That load advances `off` and `rem`.
  - The load with `rem==0` moves the FSM to DONE.
- DONE:
  - Wait until `rdata_valid_o==0`, or until it is being accepted this cycle. Write bursts pass through immediately.
  - Then pulse `done_o` for one cycle and return to IDLE.
- `cmd_valid_i` outside IDLE is ignored and not queued.
- `scratch_wr_en_o` is 0 in every state except WRITE.
- `cmd_len_i = 2^AW-1` covers the whole RAM exactly once.

## Timing
- Reset values:
  - State is IDLE.
  - `cmd_ready_o=1`, `rdata_valid_o=0`, `rdata_o=0`, `done_o=0`, `core_hold_o=0`, `wdata_ready_o=0`, `scratch_wr_en_o=0`, `scratch_addr_o=0`.
- A command is accepted on the edge; `core_hold_o` rises in the next cycle.
- Write throughput is 1 byte/cycle. The RAM write commits on the same edge as the handshake.
- Read latency is 1 cycle from the address being presented to `rdata_valid_o`. Throughput is 1 byte/cycle when `rdata_ready_i` is held high.
- `done_o` asserts in the cycle after the final byte is written, or after the final read byte is accepted. IDLE follows on the next edge.
- Reset mid-burst returns to IDLE on that edge and drops any pending read byte. RAM contents already written stay as they are.

## Structure
- Package `debug_scratch_pkg` holds:
  - The state enum `scratch_state_t`.
  - The default `RAM_LOG`/`WIDTH_LOG` values tied to `DEBUG_INST_RAM_LOG`/`DEBUG_INST_RAM_WIDTH_LOG`.
- Sub-module `debug_scratch_addr_map`: combinational mapping from linear offset to `{lane,row}`. It is reused by the bench's model.

## Test plan
- Write burst, base 2, len 7, bytes 0x11..0x88 → `scratch_addr_o` = 0x002, 0x102, …, 0x702 over 8 consecutive cycles. Row 2 must then read 0x8877665544332211. `done_o` pulses once.
- Wrap: write base 255, len 15 → bytes 8..15 land in row 0 lanes 0..7. Reading back base 255, len 15 returns identical data.
- Read backpressure: read 4 bytes with `rdata_ready_i` toggling 1,0,0,1,… → no byte is lost or duplicated, `off` advances only on loads, and `done_o` fires after the 4th acceptance.
- Write stalls: hold `wdata_valid_i` low for 3 cycles mid-burst → `scratch_wr_en_o` stays low for those cycles and the address holds.
- `cmd_valid_i` held high during a busy burst → the second command is not accepted until the cycle after `done_o`.
- Reset asserted on the 3rd byte of an 8-byte write → next cycle is IDLE with all outputs at reset values. Bytes 0–1 are written; bytes 2–7 are unchanged.
